uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a circular byte FIFO.
// Each push enqueues a byte, and the transmitter drains the FIFO one frame at a time.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrreq,
  input  logic [7:0]            data_in,
  output logic                  tx,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W   = DEPTH_LOG2;
  localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
  localparam int unsigned TIMER_W = 16;
  localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   COUNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_tx;

  logic w_full, w_empty, w_push, w_pop, w_bit_done;

  assign w_full     = (r_count == COUNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = wrreq && !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_bit_done = (r_timer == BIT_LAST);

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A push against a full FIFO is dropped even when a pop frees a slot this cycle.
      if (wrreq && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= START;
            r_tx      <= 1'b0;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              // tx takes the next bit while the shift register advances.
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign busy     = (r_state != IDLE) || !w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo.
// A serial-line monitor decodes each frame and compares it against the queue of accepted bytes.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 4;
  localparam int unsigned DL2 = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wrreq;
  logic [7:0]     data_in;
  logic           tx, full, empty, busy, overflow;
  logic [DL2:0]   count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         gap_q[$];
  logic       smp[40];
  int         mon_idx = 0;
  bit         mon_active = 1'b0;
  int         frames_done = 0;
  int         cyc = 0;
  int         last_end = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .wrreq(wrreq), .data_in(data_in),
    .tx(tx), .full(full), .empty(empty), .count(count),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_frame();
    bit         ok;
    logic [7:0] d;
    ok = (smp[0] === 1'b0) && (smp[36] === 1'b1);
    for (int b = 0; b < 10; b++)
      for (int j = 1; j < 4; j++)
        if (smp[4*b+j] !== smp[4*b]) ok = 1'b0;
    chk("frame_shape", int'(ok), 1);
    for (int b = 0; b < 8; b++) d[b] = smp[4*(b+1)];
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got byte %02h expected no frame", d);
    end else begin
      chk("frame_data", int'(d), int'(exp_q.pop_front()));
    end
  endtask

  // Serial monitor: one sample per cycle, frames are exactly 40 samples long.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        smp[0]     = tx;
        mon_idx    = 1;
        gap_q.push_back(cyc - last_end - 1);
      end
    end else begin
      smp[mon_idx] = tx;
      mon_idx++;
      if (mon_idx == 40) begin
        check_frame();
        mon_active = 1'b0;
        last_end   = cyc;
        frames_done++;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wrreq   = 1'b1;
    data_in = b;
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1;
    wrreq = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || mon_active) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_reached", int'(busy || mon_active), 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("frame_wait", int'(frames_done >= target), 1);
  endtask

  initial begin
    int f0;
    int n;
    rst_n   = 1'b0;
    wrreq   = 1'b0;
    data_in = 8'h00;
    #12;
    chk("rst_tx", int'(tx), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: tx low one cycle after the push edge, busy drops after stop bit.
    push(8'hA5, 1'b1);
    chk("a5_tx_hold", int'(tx), 1);
    chk("a5_count1", int'(count), 1);
    chk("a5_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("a5_tx_start", int'(tx), 0);
    chk("a5_empty", int'(empty), 1);
    repeat (39) @(posedge clk);
    #1;
    chk("a5_busy_stop", int'(busy), 1);
    @(posedge clk); #1;
    chk("a5_busy_fall", int'(busy), 0);
    wait_idle(200);

    // Three consecutive pushes: peak occupancy 2, frames separated by one idle cycle.
    gap_q.delete();
    f0 = frames_done;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    chk("burst_count_mid", int'(count), 1);
    push(8'h03, 1'b1);
    chk("burst_count_peak", int'(count), 2);
    n = 0;
    while (!empty && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk("burst_empty", int'(empty), 1);
    chk("burst_frames_at_empty", frames_done - f0, 2);
    chk("burst_third_active", int'(mon_active), 1);
    wait_idle(200);
    chk("burst_gap_n", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      chk("burst_gap1", gap_q[1], 1);
      chk("burst_gap2", gap_q[2], 1);
    end

    // Overflow: transmitter busy with 0x40, 16 bytes fill the FIFO, 17th is dropped.
    push(8'h40, 1'b1);
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
    chk("ovf_full", int'(full), 1);
    chk("ovf_count16", int'(count), 16);
    chk("ovf_flag_before", int'(overflow), 0);
    push(8'hEE, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count_hold", int'(count), 16);
    wait_idle(1200);

    // Wrap: fill into an idle transmitter, drain, refill; order checked by the monitor.
    for (int k = 1; k <= 16; k++) begin
      push(8'h80 + 8'(k), 1'b1);
      chk("wrap_fill_count", int'(count), (k == 1) ? 1 : k - 1);
    end
    wait_idle(1000);
    chk("wrap_drained_count", int'(count), 0);
    push(8'hC1, 1'b1);
    chk("refill_count1", int'(count), 1);
    push(8'hC2, 1'b1);
    chk("refill_count2", int'(count), 1);
    push(8'hC3, 1'b1);
    chk("refill_count3", int'(count), 2);
    wait_idle(300);
    chk("ovf_sticky", int'(overflow), 1);

    // Reset clears the sticky flag.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full FIFO, push on the same edge as the IDLE pop: push dropped, count 15.
    f0 = frames_done;
    push(8'h60, 1'b1);
    for (int i = 0; i < 16; i++) push(8'h70 + 8'(i), 1'b1);
    chk("pp_full", int'(full), 1);
    wait_frames(f0 + 1, 200);
    @(posedge clk);
    @(negedge clk);
    wrreq   = 1'b1;
    data_in = 8'hDD;
    @(posedge clk); #1;
    wrreq = 1'b0;
    chk("pp_count15", int'(count), 15);
    chk("pp_overflow", int'(overflow), 1);
    chk("pp_full_after", int'(full), 0);

    // Reset during the DATA bits of the next frame: everything aborts and stays quiet.
    n = 0;
    while (!(mon_active && mon_idx == 12) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("mid_data_reached", int'(mon_active && mon_idx == 12), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_count", int'(count), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_busy", int'(busy), 0);
    exp_q.delete();
    f0 = frames_done;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("abort_no_frames", frames_done - f0, 0);
    chk("abort_quiet", int'(mon_active), 0);
    chk("abort_tx_idle", int'(tx), 1);
    chk("abort_empty", int'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
